fifo_arbiter: RTL and testbench
===============================

Name: fifo_arbiter

Overview:
- Schedules the single-port FIFO (one operation per clock, selected by wnr/en) among two producers and one consumer.
- Round-robin arbitration grants one operation per cycle. A shadow occupancy count, updated at grant time, prevents overflow and underflow even with operations in flight.
- Sits between the requesters (button/debounce logic, test sources) and the FIFO instance.
- Also cross-checks the FIFO's full/empty flags against the shadow count when the pipeline is idle.

Parameters:
- DW, 4, data width of FIFO words.
- DEPTH, 8, FIFO capacity in words. Must match the FIFO instance.
- CW, 4, width of the count output. Must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr0_req  in  1  producer 0 write request, level.
- wr0_data  in  DW  producer 0 word. Held stable while wr0_req is high and wr0_gnt is low.
- wr0_gnt  out  1  one-cycle grant to producer 0.
- wr1_req  in  1  producer 1 write request.
- wr1_data  in  DW  producer 1 word.
- wr1_gnt  out  1  one-cycle grant to producer 1.
- rd_req  in  1  consumer read request, level.
- rd_gnt  out  1  one-cycle grant to consumer.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  DW  read word, a combinational passthrough of fifo_dout.
- fifo_wnr  out  1  1 = write, 0 = read.
- fifo_en  out  1  FIFO operation enable.
- fifo_din  out  DW  write data to FIFO.
- fifo_dout  in  DW  FIFO read data, valid the cycle after the read edge.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- count  out  CW  shadow occupancy, including granted operations.
- sync_err  out  1  sticky flag-mismatch error.

Behaviour:
- Reset (synchronous, rst=1 at edge) clears:
  - all gnt outputs, rd_valid, fifo_en, fifo_wnr, fifo_din, count, sync_err, idle counter;
  - the priority pointer, which returns to wr0.
- Eligibility is evaluated at each edge from the registered count:
  - wr0 eligible = wr0_req && count<DEPTH; wr1 likewise;
  - rd eligible = rd_req && count>0.
- Priority order is rotating. The pointer p is in {0=wr0, 1=wr1, 2=rd}. Order is p, p+1, p+2 mod 3. The first eligible requester wins.
- After a grant to index i, p <= (i+1) mod 3. With no grant, p is unchanged.
- Decision edge E, grant to a writer:
  - wrX_gnt=1, fifo_en=1, fifo_wnr=1 during cycle E+1;
  - fifo_din <= wrX_data sampled at E;
  - count <= count+1.
- Decision edge E, grant to the reader:
  - rd_gnt=1, fifo_en=1, fifo_wnr=0 during cycle E+1;
  - count <= count-1.
- Otherwise fifo_en=0, all gnt=0, and fifo_din holds its value.
- At most one gnt and one fifo_en per cycle. Latency from request to gnt is 1 cycle when uncontended.
- Read data path: the FIFO acts at edge E+1. rd_valid=1 during cycle E+2, with rd_data = fifo_dout.
- Requester handshake:
  - a requester holds req and data until it sees gnt;
  - if req is still high at the edge closing the gnt cycle, it is a new request;
  - back-to-back grants to the same requester are allowed only when the other requesters are ineligible.
- The count never exceeds DEPTH and never goes below 0. A request at a boundary simply waits with its gnt low.
- Full-boundary rule: with count==DEPTH-1 and both writers requesting, only the higher-priority writer is granted. The other waits.
- Simultaneous read and writes: only one operation per cycle. Rotation guarantees each eligible requester is granted within 3 cycles.
- Flag check: the idle counter increments when fifo_en=0 and saturates at 2; it resets to 0 on any fifo_en=1.
  - When the counter reaches 2, sync_err is set if fifo_full != (count==DEPTH) or fifo_empty != (count==0).
  - sync_err is sticky until rst.
- Reset mid-operation: in-flight grants are dropped. fifo_en is 0 in the cycle after the rst edge. The FIFO must be reset by the same rst so the count and the FIFO agree.

Test Plan:
- Reset, then single write: rst 2 cycles; wr0_req=1, wr0_data=4'hA → wr0_gnt, fifo_en=1, fifo_wnr=1, fifo_din=A one cycle after the request edge; count=1; sync_err stays 0.
- Fill to limit: DEPTH=8, wr0_req held high with incrementing data 0..9 → exactly 8 grants, count=8, then wr0_gnt stays 0; fifo_full=1; no sync_err.
- Contention rotation: count=3, wr0, wr1 and rd all held high for 6 cycles → grant order wr0, wr1, rd, wr0, wr1, rd; count ends at 5.
- Read path: write 5,6 then rd_req → rd_gnt; rd_valid pulses 1 cycle later with rd_data=5, then again with 6; count=0, after which rd_gnt is never asserted.
- Boundary contention: count=7, wr0 and wr1 requesting, p=1 → only wr1 is granted, count=8, wr0 waits; a subsequent read frees the slot and wr0 is granted within 3 cycles.
- Error and reset: force fifo_empty=0 with count=0 for 3 idle cycles → sync_err=1 and stays; mid-stream rst → all outputs 0 and count=0 after the edge, sync_err cleared.

Source files
------------

// File: rtl/fifo_arbiter.sv
// Round-robin scheduler for a single-port FIFO shared by two producers and one consumer.
// A shadow count updated at grant time guards against overflow/underflow and cross-checks the FIFO flags.
module fifo_arbiter #(
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_req,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_gnt,
    input  logic          wr1_req,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_gnt,
    input  logic          rd_req,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          fifo_wnr,
    output logic          fifo_en,
    output logic [DW-1:0] fifo_din,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    output logic [CW-1:0] count,
    output logic          sync_err
);

    typedef enum logic [1:0] {
        PRI_WR0 = 2'd0,
        PRI_WR1 = 2'd1,
        PRI_RD  = 2'd2
    } priState_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_WR0,
        SEL_WR1,
        SEL_RD
    } sel_t;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    priState_t ptr, ptrNext;
    sel_t      sel;
    logic      wr0Elig, wr1Elig, rdElig;
    logic [1:0] idleCnt;

    always_ff @(posedge clk) begin
        if (rst) ptr <= PRI_WR0;
        else     ptr <= ptrNext;
    end

    always_comb begin
        wr0Elig = wr0_req && (count < FULL_CNT);
        wr1Elig = wr1_req && (count < FULL_CNT);
        rdElig  = rd_req && (count != '0);
        sel     = SEL_NONE;
        ptrNext = ptr;
        case (ptr)
            PRI_WR0: begin
                if      (wr0Elig) sel = SEL_WR0;
                else if (wr1Elig) sel = SEL_WR1;
                else if (rdElig)  sel = SEL_RD;
            end
            PRI_WR1: begin
                if      (wr1Elig) sel = SEL_WR1;
                else if (rdElig)  sel = SEL_RD;
                else if (wr0Elig) sel = SEL_WR0;
            end
            default: begin
                if      (rdElig)  sel = SEL_RD;
                else if (wr0Elig) sel = SEL_WR0;
                else if (wr1Elig) sel = SEL_WR1;
            end
        endcase
        case (sel)
            SEL_WR0: ptrNext = PRI_WR1;
            SEL_WR1: ptrNext = PRI_RD;
            SEL_RD:  ptrNext = PRI_WR0;
            default: ptrNext = ptr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr0_gnt  <= 1'b0;
            wr1_gnt  <= 1'b0;
            rd_gnt   <= 1'b0;
            rd_valid <= 1'b0;
            fifo_en  <= 1'b0;
            fifo_wnr <= 1'b0;
            fifo_din <= '0;
            count    <= '0;
            sync_err <= 1'b0;
            idleCnt  <= '0;
        end else begin
            wr0_gnt  <= (sel == SEL_WR0);
            wr1_gnt  <= (sel == SEL_WR1);
            rd_gnt   <= (sel == SEL_RD);
            fifo_en  <= (sel != SEL_NONE);
            rd_valid <= rd_gnt;
            case (sel)
                SEL_WR0: begin
                    fifo_wnr <= 1'b1;
                    fifo_din <= wr0_data;
                    count    <= count + 1'b1;
                end
                SEL_WR1: begin
                    fifo_wnr <= 1'b1;
                    fifo_din <= wr1_data;
                    count    <= count + 1'b1;
                end
                SEL_RD: begin
                    fifo_wnr <= 1'b0;
                    count    <= count - 1'b1;
                end
                default: ;
            endcase
            if (fifo_en)              idleCnt <= '0;
            else if (idleCnt != 2'd2) idleCnt <= idleCnt + 2'd1;
            // Two quiet cycles guarantee nothing is in flight, so flags must match the count.
            if ((idleCnt == 2'd2) &&
                ((fifo_full != (count == FULL_CNT)) || (fifo_empty != (count == '0))))
                sync_err <= 1'b1;
        end
    end

    assign rd_data = fifo_dout;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a behavioural single-port FIFO attached.
module tb_fifo_arbiter;

    localparam int DW = 4;
    localparam int DEPTH = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr0_req, wr1_req, rd_req;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_gnt, wr1_gnt, rd_gnt, rd_valid;
    logic [DW-1:0] rd_data, fifo_din, fifo_dout;
    logic          fifo_wnr, fifo_en, fifo_full, fifo_empty;
    logic [CW-1:0] count;
    logic          sync_err;
    logic          forceNotEmpty;

    int nChecks = 0;
    int nFails = 0;

    fifo_arbiter #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .wr0_req(wr0_req), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
        .wr1_req(wr1_req), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_wnr(fifo_wnr), .fifo_en(fifo_en), .fifo_din(fifo_din),
        .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .count(count), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: one operation per edge, read data registered.
    logic [DW-1:0] mem [DEPTH];
    logic [2:0]    wp, rp;
    int            occ;
    logic [DW-1:0] modelDout;

    always @(posedge clk) begin
        if (rst) begin
            wp <= '0; rp <= '0; occ <= 0; modelDout <= '0;
        end else if (fifo_en) begin
            if (fifo_wnr && occ < DEPTH) begin
                mem[wp] <= fifo_din; wp <= wp + 3'd1; occ <= occ + 1;
            end else if (!fifo_wnr && occ > 0) begin
                modelDout <= mem[rp]; rp <= rp + 3'd1; occ <= occ - 1;
            end
        end
    end

    assign fifo_dout  = modelDout;
    assign fifo_full  = (occ == DEPTH);
    assign fifo_empty = forceNotEmpty ? 1'b0 : (occ == 0);

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // who: 0=wr0, 1=wr1, 2=rd. Holds the request until its grant is seen, then drops it.
    task automatic request(input int who, input logic [DW-1:0] d);
        logic got;
        got = 1'b0;
        case (who)
            0:       begin wr0_data = d; wr0_req = 1'b1; end
            1:       begin wr1_data = d; wr1_req = 1'b1; end
            default: rd_req = 1'b1;
        endcase
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            case (who)
                0:       got = wr0_gnt;
                1:       got = wr1_gnt;
                default: got = rd_gnt;
            endcase
        end
        case (who)
            0:       wr0_req = 1'b0;
            1:       wr1_req = 1'b0;
            default: rd_req = 1'b0;
        endcase
        checkVal("req_gnt_wait", 32'(got), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] rotExp [6];
        int grants;
        logic got;
        rotExp = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
        rst = 1'b1;
        wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
        wr0_data = '0; wr1_data = '0;
        forceNotEmpty = 1'b0;

        // Reset state
        doReset();
        checkVal("rst_gnt", 32'({wr0_gnt, wr1_gnt, rd_gnt}), 0);
        checkVal("rst_en", 32'(fifo_en), 0);
        checkVal("rst_wnr", 32'(fifo_wnr), 0);
        checkVal("rst_din", 32'(fifo_din), 0);
        checkVal("rst_count", 32'(count), 0);
        checkVal("rst_valid", 32'(rd_valid), 0);
        checkVal("rst_err", 32'(sync_err), 0);

        // Single write
        wr0_data = 4'hA; wr0_req = 1'b1;
        tick();
        checkVal("w1_gnt", 32'(wr0_gnt), 1);
        checkVal("w1_other", 32'({wr1_gnt, rd_gnt}), 0);
        checkVal("w1_en", 32'(fifo_en), 1);
        checkVal("w1_wnr", 32'(fifo_wnr), 1);
        checkVal("w1_din", 32'(fifo_din), 32'hA);
        checkVal("w1_count", 32'(count), 1);
        wr0_req = 1'b0;
        tick();
        checkVal("w1_gnt_off", 32'(wr0_gnt), 0);
        checkVal("w1_en_off", 32'(fifo_en), 0);
        repeat (4) tick();
        checkVal("w1_err", 32'(sync_err), 0);

        // Fill to limit with wr0 held high
        doReset();
        grants = 0;
        wr0_data = 4'd0; wr0_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr0_gnt) begin
                checkVal("fill_din", 32'(fifo_din), 32'(grants));
                grants++;
                wr0_data = wr0_data + 4'd1;
            end
        end
        checkVal("fill_grants", 32'(grants), 8);
        checkVal("fill_count", 32'(count), 8);
        checkVal("fill_gnt_stop", 32'(wr0_gnt), 0);
        wr0_req = 1'b0;
        repeat (4) tick();
        checkVal("fill_err", 32'(sync_err), 0);

        // Contention rotation from count=3, pointer at wr0
        doReset();
        for (int k = 1; k <= 4; k++) request(0, 4'(k));
        request(2, '0);
        checkVal("rot_pre_count", 32'(count), 3);
        wr0_data = 4'd7; wr1_data = 4'd8;
        wr0_req = 1'b1; wr1_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkVal("rot_order", 32'({wr0_gnt, wr1_gnt, rd_gnt}), 32'(rotExp[i]));
        end
        wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
        checkVal("rot_count", 32'(count), 5);
        repeat (3) tick();

        // Read data path
        doReset();
        request(0, 4'd5);
        request(0, 4'd6);
        rd_req = 1'b1;
        tick();
        checkVal("rd_gnt1", 32'(rd_gnt), 1);
        checkVal("rd_wnr", 32'(fifo_wnr), 0);
        checkVal("rd_count1", 32'(count), 1);
        tick();
        checkVal("rd_valid1", 32'(rd_valid), 1);
        checkVal("rd_data1", 32'(rd_data), 5);
        checkVal("rd_gnt2", 32'(rd_gnt), 1);
        checkVal("rd_count2", 32'(count), 0);
        tick();
        checkVal("rd_valid2", 32'(rd_valid), 1);
        checkVal("rd_data2", 32'(rd_data), 6);
        checkVal("rd_gnt_empty", 32'(rd_gnt), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("rd_gnt_empty", 32'(rd_gnt), 0);
        end
        checkVal("rd_valid_off", 32'(rd_valid), 0);
        rd_req = 1'b0;

        // Boundary contention at count=7 with pointer at wr1
        doReset();
        for (int k = 1; k <= 7; k++) request(0, 4'(k));
        wr0_data = 4'hD; wr1_data = 4'hE;
        wr0_req = 1'b1; wr1_req = 1'b1;
        tick();
        checkVal("bnd_wr1", 32'(wr1_gnt), 1);
        checkVal("bnd_wr0_wait", 32'(wr0_gnt), 0);
        checkVal("bnd_din", 32'(fifo_din), 32'hE);
        checkVal("bnd_count_full", 32'(count), 8);
        wr1_req = 1'b0;
        tick();
        checkVal("bnd_wr0_full", 32'(wr0_gnt), 0);
        checkVal("bnd_count_hold", 32'(count), 8);
        request(2, '0);
        checkVal("bnd_count_rd", 32'(count), 7);
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            tick();
            got = wr0_gnt;
        end
        wr0_req = 1'b0;
        checkVal("bnd_wr0_late", 32'(got), 1);
        checkVal("bnd_din_late", 32'(fifo_din), 32'hD);
        checkVal("bnd_count_end", 32'(count), 8);

        // Flag mismatch sets sticky error; reset mid-operation clears everything
        doReset();
        forceNotEmpty = 1'b1;
        tick();
        tick();
        checkVal("err_early", 32'(sync_err), 0);
        tick();
        checkVal("err_set", 32'(sync_err), 1);
        forceNotEmpty = 1'b0;
        repeat (3) tick();
        checkVal("err_sticky", 32'(sync_err), 1);
        wr0_data = 4'h3; wr0_req = 1'b1;
        tick();
        checkVal("mid_gnt", 32'(wr0_gnt), 1);
        rst = 1'b1;
        tick();
        checkVal("mid_rst_en", 32'(fifo_en), 0);
        checkVal("mid_rst_gnt", 32'({wr0_gnt, wr1_gnt, rd_gnt}), 0);
        checkVal("mid_rst_count", 32'(count), 0);
        checkVal("mid_rst_err", 32'(sync_err), 0);
        checkVal("mid_rst_din", 32'(fifo_din), 0);
        rst = 1'b0;
        wr0_req = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
